div_seq: RTL

//  Iterative restoring divider: the inverse of the ALU's add path, producing quotient and remainder
//  by repeated shift-and-subtract. Sits beside the ALU in the EX stage; the pipeline stalls on busy.

---
 rtl/div_seq_pkg.sv | 15 +
 rtl/div_step.sv | 30 +++
 rtl/div_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared state encoding and sizing helper for the sequential divider
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIN  = 2'd2
  } div_state_e;

  // Bits needed to hold the step counter, which runs WIDTH-1 down to 0.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-and-subtract step of the divider
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] sum;
  logic             no_borrow;
  logic             unused_sum_msb;

  // Shift the top quotient bit into the partial remainder.
  assign r_sh = {r, q[WIDTH-1]};

  // r_sh - d as r_sh + ~d + 1; the carry out of the top bit means no borrow.
  assign sum = {1'b0, r_sh} + {1'b0, ~{1'b0, d}} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign no_borrow = sum[WIDTH+1];

  // On no borrow the difference is below d, so it always fits in WIDTH bits.
  assign unused_sum_msb = sum[WIDTH];

  assign r_next = no_borrow ? sum[WIDTH-1:0] : r_sh[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], no_borrow};

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative restoring divider, signed/unsigned, start/busy/done handshake
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // Magnitudes in WIDTH-bit unsigned; the most negative value maps to 2^(WIDTH-1).
  assign a_mag = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
  assign b_mag = (is_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .q      (q_q),
    .d      (dv_q),
    .r_next (r_next),
    .q_next (q_next)
  );

  // State, datapath and output registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dv_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dv_q    <= dv_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state: accept in IDLE, one step per cycle in CALC, sign fix-up and publish in FIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dv_d    = dv_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          qneg_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_d = is_signed & dividend[WIDTH-1];
          dv_d   = b_mag;
          r_d    = '0;
          cnt_d  = CW'(WIDTH - 1);
          if (divisor == '0) begin
            // Keep the raw dividend; it becomes the remainder unchanged.
            dz_d    = 1'b1;
            q_d     = dividend;
            state_d = DIV_FIN;
          end else begin
            dz_d    = 1'b0;
            q_d     = a_mag;
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DIV_FIN;
        end
      end
      DIV_FIN: begin
        done_d  = 1'b1;
        state_d = DIV_IDLE;
        if (dz_q) begin
          quot_d = '1;
          rem_d  = q_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = qneg_q ? (~q_q + 1'b1) : q_q;
          rem_d  = rneg_q ? (~r_q + 1'b1) : r_q;
          dbz_d  = 1'b0;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != DIV_IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
